// File: rtl/line_pkg.sv
// ============================================================================
// Module   : line_pkg
// Purpose  : Shared types, FSM state codes and step directions for the line rasteriser.
// Revision : 1.0
// ============================================================================
`default_nettype none

package line_pkg;

    localparam int LINE_COORD_W = 11;

    typedef logic [LINE_COORD_W-1:0]        coord_t;
    typedef logic signed [LINE_COORD_W+1:0] err_t;

    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_DRAW  = 2'd2;

    localparam logic STEP_POS = 1'b0;
    localparam logic STEP_NEG = 1'b1;

endpackage

`default_nettype wire

// File: rtl/line_octant_setup.sv
// ============================================================================
// Module   : line_octant_setup
// Purpose  : Combinational deltas, step directions, initial error and point count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module line_octant_setup
    import line_pkg::*;
#(
    parameter int COORD_W = LINE_COORD_W
) (
    input  logic [COORD_W-1:0]        i_x0,
    input  logic [COORD_W-1:0]        i_y0,
    input  logic [COORD_W-1:0]        i_x1,
    input  logic [COORD_W-1:0]        i_y1,
    output logic signed [COORD_W+1:0] o_dx,
    output logic signed [COORD_W+1:0] o_dy,
    output logic signed [COORD_W+1:0] o_err,
    output logic                      o_sx,
    output logic                      o_sy,
    output logic [COORD_W-1:0]        o_cnt
);

    localparam int EW = COORD_W + 2;

    logic signed [EW-1:0] w_ddx;
    logic signed [EW-1:0] w_ddy;

    assign w_ddx = $signed({2'b00, i_x1}) - $signed({2'b00, i_x0});
    assign w_ddy = $signed({2'b00, i_y1}) - $signed({2'b00, i_y0});

    assign o_sx  = w_ddx[EW-1] ? STEP_NEG : STEP_POS;
    assign o_sy  = w_ddy[EW-1] ? STEP_NEG : STEP_POS;
    assign o_dx  = w_ddx[EW-1] ? -w_ddx : w_ddx;
    assign o_dy  = w_ddy[EW-1] ? -w_ddy : w_ddy;
    assign o_err = o_dx - o_dy;

    // Both deltas are non-negative and below 2**COORD_W, so the low bits hold the max.
    assign o_cnt = (o_dx > o_dy) ? o_dx[COORD_W-1:0] : o_dy[COORD_W-1:0];

endmodule

`default_nettype wire

// File: rtl/line_raster_stream.sv
// ============================================================================
// Module   : line_raster_stream
// Purpose  : All-octant Bresenham rasteriser, one pixel per cycle on a valid/ready
//            stream. Optional screen clipping when LINE_CLIP_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module line_raster_stream
    import line_pkg::*;
#(
    parameter int COORD_W  = LINE_COORD_W,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               abort,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam int EW = COORD_W + 2;
`ifdef LINE_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif
    localparam logic [31:0] SCR_W = 32'(SCREEN_W);
    localparam logic [31:0] SCR_H = 32'(SCREEN_H);

    state_t               r_state;
    logic [COORD_W-1:0]   r_cx0, r_cy0, r_cx1, r_cy1;
    logic signed [EW-1:0] r_dx, r_dy, r_err;
    logic                 r_sx, r_sy;
    logic [COORD_W-1:0]   r_cnt;
    logic [COORD_W-1:0]   r_x, r_y;
    logic                 r_done;

    logic signed [EW-1:0] w_dx, w_dy, w_err;
    logic                 w_sx, w_sy;
    logic [COORD_W-1:0]   w_cnt;

    line_octant_setup #(.COORD_W(COORD_W)) u_setup (
        .i_x0  (r_cx0),
        .i_y0  (r_cy0),
        .i_x1  (r_cx1),
        .i_y1  (r_cy1),
        .o_dx  (w_dx),
        .o_dy  (w_dy),
        .o_err (w_err),
        .o_sx  (w_sx),
        .o_sy  (w_sy),
        .o_cnt (w_cnt)
    );

    logic                 w_inbounds, w_onscreen, w_draw, w_step, w_final;
    logic                 w_xstep, w_ystep;
    logic signed [EW:0]   w_e2, w_ndy, w_dxe;
    logic signed [EW-1:0] w_err_next;
    logic [COORD_W-1:0]   w_x_next, w_y_next;

    assign w_inbounds = (32'(r_x) < SCR_W) && (32'(r_y) < SCR_H);
    assign w_onscreen = !CLIP_EN || w_inbounds;
    assign w_draw     = (r_state == ST_DRAW);
    assign w_final    = (r_cnt == '0);
    // Off-screen points advance without waiting for the sink.
    assign w_step     = w_draw && (out_ready || !w_onscreen);

    assign w_e2    = {r_err, 1'b0};
    assign w_ndy   = -{r_dy[EW-1], r_dy};
    assign w_dxe   = {r_dx[EW-1], r_dx};
    assign w_xstep = (w_e2 > w_ndy);
    assign w_ystep = (w_e2 < w_dxe);

    assign w_err_next = r_err - (w_xstep ? r_dy : '0) + (w_ystep ? r_dx : '0);
    assign w_x_next   = !w_xstep ? r_x :
                        (r_sx == STEP_NEG) ? r_x - COORD_W'(1) : r_x + COORD_W'(1);
    assign w_y_next   = !w_ystep ? r_y :
                        (r_sy == STEP_NEG) ? r_y - COORD_W'(1) : r_y + COORD_W'(1);

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = w_draw && w_onscreen;
    assign out_last  = out_valid && w_final;
    assign out_x     = r_x;
    assign out_y     = r_y;
    assign done      = r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cx0   <= '0;
            r_cy0   <= '0;
            r_cx1   <= '0;
            r_cy1   <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_err   <= '0;
            r_sx    <= STEP_POS;
            r_sy    <= STEP_POS;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cmd_valid) begin
                            r_cx0   <= x0;
                            r_cy0   <= y0;
                            r_cx1   <= x1;
                            r_cy1   <= y1;
                            r_state <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        r_dx    <= w_dx;
                        r_dy    <= w_dy;
                        r_err   <= w_err;
                        r_sx    <= w_sx;
                        r_sy    <= w_sy;
                        r_cnt   <= w_cnt;
                        r_x     <= r_cx0;
                        r_y     <= r_cy0;
                        r_state <= ST_DRAW;
                    end
                    ST_DRAW: begin
                        if (w_step) begin
                            if (w_final) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_err <= w_err_next;
                                r_x   <= w_x_next;
                                r_y   <= w_y_next;
                                r_cnt <= r_cnt - COORD_W'(1);
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_line_raster_stream.sv
// ============================================================================
// Module   : tb_line_raster_stream
// Purpose  : Randomised self-checking bench against a point-list line model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_line_raster_stream;

    localparam int CW = 11;
    localparam int SW = 8;
    localparam int SH = 480;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          abort = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_x, out_y;
    logic          out_last;
    logic          busy;
    logic          done;

    line_raster_stream #(.COORD_W(CW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk       (clk),
        .reset     (reset),
        .abort     (abort),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_x[$];
    int exp_y[$];
    int exp_l[$];
    int exp_total;
    int exp_first;
    int beats_seen;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit on_screen(input int px, input int py);
`ifdef LINE_CLIP_EN
        return (px < SW) && (py < SH);
`else
        return 1'b1;
`endif
    endfunction

    // Walks the line point by point with the classic integer error term.
    function automatic void model(input int ax0, input int ay0, input int ax1, input int ay1);
        int dx, dy, sx, sy, err, e2, n, px, py;
        exp_x.delete(); exp_y.delete(); exp_l.delete();
        dx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
        dy = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
        sx = (ax1 >= ax0) ? 1 : -1;
        sy = (ay1 >= ay0) ? 1 : -1;
        err = dx - dy;
        n = (dx > dy) ? dx : dy;
        px = ax0; py = ay0;
        exp_total = n + 1;
        exp_first = -1;
        for (int i = 0; i <= n; i++) begin
            if (on_screen(px, py)) begin
                if (exp_first < 0) exp_first = i;
                exp_x.push_back(px);
                exp_y.push_back(py);
                exp_l.push_back((i == n) ? 1 : 0);
            end
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; px += sx; end
            if (e2 < dx)  begin err += dx; py += sy; end
        end
    endfunction

    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int stall, input int abort_at);
        int  c = 0;
        int  first_valid = -1;
        bit  done_seen = 1'b0;
        bit  prev_stall = 1'b0;
        bit  rdy;
        int  px = 0, py = 0, pl = 0;
        model(ax0, ay0, ax1, ay1);
        beats_seen = 0;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        cmd_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        x0 = CW'($urandom); y0 = CW'($urandom);
        check("setup_no_valid", out_valid, 0);
        check("setup_busy", busy, 1);
        while (c < 3000) begin
            if (prev_stall) begin
                check("stall_x", out_x, px);
                check("stall_y", out_y, py);
                check("stall_last", out_last, pl);
            end
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            if (out_valid && first_valid < 0) first_valid = c;
            rdy = (stall == 0) || ($urandom_range(0, 99) >= 50);
            if (out_valid && abort_at >= 0 && beats_seen == abort_at) begin
                abort = 1'b1;
                out_ready = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                out_ready = 1'b0;
                check("abort_valid", out_valid, 0);
                check("abort_cmd_ready", cmd_ready, 1);
                for (int k = 0; k < 6; k++) begin
                    check("abort_no_done", done, 0);
                    @(negedge clk);
                end
                return;
            end
            out_ready = rdy;
            if (out_valid && rdy) begin
                if (beats_seen < exp_x.size()) begin
                    check("beat_x", out_x, exp_x[beats_seen]);
                    check("beat_y", out_y, exp_y[beats_seen]);
                    check("beat_last", out_last, exp_l[beats_seen]);
                end else begin
                    check("extra_beat", beats_seen, exp_x.size() - 1);
                end
                beats_seen++;
            end
            prev_stall = out_valid && !rdy;
            px = out_x; py = out_y; pl = out_last;
            @(negedge clk);
            c++;
        end
        out_ready = 1'b0;
        check("done_seen", done_seen, 1);
        check("beat_count", beats_seen, exp_x.size());
        if (exp_first >= 0) check("first_valid_latency", first_valid, exp_first + 1);
        if (stall == 0) check("done_latency", c, exp_total + 1);
        check("done_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        check("done_one_pulse", done, 0);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'($urandom); abort = 1'($urandom); out_ready = 1'($urandom);
            x0 = CW'($urandom); y0 = CW'($urandom); x1 = CW'($urandom); y1 = CW'($urandom);
            @(negedge clk);
            check("rst_valid", out_valid, 0);
            check("rst_x", out_x, 0);
            check("rst_y", out_y, 0);
            check("rst_done", done, 0);
            check("rst_busy", busy, 0);
            check("rst_last", out_last, 0);
        end
        cmd_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);

        run_line(1, 1, 12, 5, 0, -1);
`ifndef LINE_CLIP_EN
        check("diag_beats", beats_seen, 12);
`endif
        run_line(1, 1, 1, 15, 0, -1);
        run_line(10, 2, 2, 6, 0, -1);
        run_line(4, 4, 4, 4, 0, -1);
        run_line(0, 0, 20, 7, 0, -1);
        run_line(0, 0, 20, 7, 1, -1);
        run_line(0, 0, 30, 30, 0, 4);
        run_line(2, 2, 3, 3, 0, -1);
`ifdef LINE_CLIP_EN
        run_line(5, 0, 12, 0, 0, -1);
        check("clip_beats", beats_seen, 3);
`endif
        run_line(30, 25, 0, 3, 1, -1);

        for (int t = 0; t < 20; t++) begin
            run_line(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 1)), -1);
        end

        // Asynchronous reset in the middle of a line.
        @(negedge clk);
        x0 = 0; y0 = 0; x1 = 30; y1 = 30;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_x", out_x, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_output", out_valid, 0);
            check("midrst_no_done", done, 0);
        end
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
